// File: rtl/rram_pulse_sequencer.sv
// RRAM pulse sequencer: a Wishbone-controlled FSM that selects one RRAM cell
// and drives SETUP / PULSE / HOLD / SAMPLE / DONE phases for READ, SET and RESET.
// Optional feature: define RRAM_VERIFY_EN to add a read-verify loop after SET/RESET,
// with up to MAX_RETRY re-pulses before reporting fail.
module rram_pulse_sequencer #(
   parameter int unsigned ROW_W     = 4,
   parameter int unsigned COL_W     = 4,
   parameter int unsigned MAX_RETRY = 7
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic [(1<<ROW_W)-1:0]   wl_en,
   output logic [(1<<COL_W)-1:0]   bl_en,
   output logic                    op_set,
   output logic                    op_reset,
   output logic                    pulse,
   output logic                    sense_en,
   input  logic                    sense_in,
   output logic                    irq
);

   localparam int unsigned NumRows = 1 << ROW_W;
   localparam int unsigned NumCols = 1 << COL_W;

   localparam logic [NumRows-1:0] RowOne = NumRows'(1);
   localparam logic [NumCols-1:0] ColOne = NumCols'(1);

   localparam logic [1:0] OpRead  = 2'd0;
   localparam logic [1:0] OpSet   = 2'd1;
   localparam logic [1:0] OpReset = 2'd2;
   localparam logic [1:0] OpRsvd  = 2'd3;

   localparam logic [1:0] AdrCtrl   = 2'd0;
   localparam logic [1:0] AdrTiming = 2'd1;
   localparam logic [1:0] AdrStatus = 2'd2;

   localparam logic [7:0] PwReset = 8'd10;
   localparam logic [3:0] SuReset = 4'd2;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StSample,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [7:0]         pw_q, pw_d;       // pulse width latched at start, never 0
   logic [3:0]         su_q, su_d;       // setup length latched at start, never 0
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               result_q, result_d;
   logic               fail_q, fail_d;
   logic [3:0]         retries_q, retries_d;

   logic               ack_q;
   logic [31:0]        rdata_q, rdata_d;
   logic [7:0]         pw_cfg_q;
   logic [3:0]         su_cfg_q;

   logic               wb_req;
   logic               wr_ctrl, wr_timing;
   logic               start_req, start_ok, start_bad;
   logic               busy;
   logic               arr_active;

`ifdef RRAM_VERIFY_EN
   localparam logic [3:0] MaxRetry = MAX_RETRY[3:0];
`else
   logic [3:0] unused_max_retry;
   assign unused_max_retry = MAX_RETRY[3:0];
`endif

   logic unused_bus;
   assign unused_bus = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

   // A new request is taken only when no ack is outstanding, giving one ack per transfer.
   assign wb_req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign wr_ctrl   = wb_req & wbs_we_i & (wbs_adr_i[3:2] == AdrCtrl);
   assign wr_timing = wb_req & wbs_we_i & (wbs_adr_i[3:2] == AdrTiming);
   assign start_req = wr_ctrl & wbs_dat_i[0];
   assign start_ok  = start_req & (state_q == StIdle) & (wbs_dat_i[2:1] != OpRsvd);
   assign start_bad = start_req & ~start_ok;

   assign busy       = (state_q != StIdle);
   assign arr_active = (state_q == StSetup) || (state_q == StPulse) ||
                       (state_q == StHold)  || (state_q == StSample);

   // Read data mux, registered so it is valid alongside ack.
   always_comb begin
      rdata_d = 32'd0;
      unique case (wbs_adr_i[3:2])
         AdrTiming: rdata_d = {20'd0, su_cfg_q, pw_cfg_q};
         AdrStatus: rdata_d = {20'd0, retries_q, 3'd0, fail_q, err_q, result_q, done_q, busy};
         default:   rdata_d = 32'd0;
      endcase
   end

   // Wishbone ack, read data and TIMING configuration register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_q    <= 1'b0;
         rdata_q  <= 32'd0;
         pw_cfg_q <= PwReset;
         su_cfg_q <= SuReset;
      end else begin
         ack_q <= wb_req;
         if (wb_req && !wbs_we_i) begin
            rdata_q <= rdata_d;
         end
         if (wr_timing) begin
            pw_cfg_q <= wbs_dat_i[7:0];
            su_cfg_q <= wbs_dat_i[11:8];
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdata_q;

   // Sequencer next-state, operand latching and status updates.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      row_d     = row_q;
      col_d     = col_q;
      pw_d      = pw_q;
      su_d      = su_q;
      done_d    = done_q;
      err_d     = err_q;
      result_d  = result_q;
      fail_d    = fail_q;
      retries_d = retries_q;

      if (start_bad) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d   = StSetup;
               cnt_d     = 8'd0;
               op_d      = wbs_dat_i[2:1];
               row_d     = wbs_dat_i[4 +: ROW_W];
               col_d     = wbs_dat_i[8 +: COL_W];
               pw_d      = (pw_cfg_q == 8'd0) ? 8'd1 : pw_cfg_q;
               su_d      = (su_cfg_q == 4'd0) ? 4'd1 : su_cfg_q;
               done_d    = 1'b0;
               err_d     = 1'b0;
               fail_d    = 1'b0;
               retries_d = 4'd0;
            end
         end
         StSetup: begin
            if (cnt_q == ({4'd0, su_q} - 8'd1)) begin
               state_d = StPulse;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StPulse: begin
            if (cnt_q == (pw_q - 8'd1)) begin
               state_d = StHold;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StHold: begin
            cnt_d = 8'd0;
            if (op_q == OpRead) begin
               state_d = StSample;
            end else begin
`ifdef RRAM_VERIFY_EN
               state_d = StSample;
`else
               state_d = StDone;
               done_d  = 1'b1;
`endif
            end
         end
         StSample: begin
            if (cnt_q == 8'd0) begin
               cnt_d = 8'd1;
            end else begin
               cnt_d    = 8'd0;
               result_d = sense_in;
               if (op_q == OpRead) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
`ifdef RRAM_VERIFY_EN
                  // SET should leave the cell low-resistance (1), RESET high-resistance (0).
                  if (sense_in == (op_q == OpSet)) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                     fail_d  = 1'b0;
                  end else if (retries_q < MaxRetry) begin
                     state_d   = StSetup;
                     retries_d = retries_q + 4'd1;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                     fail_d  = 1'b1;
                  end
`else
                  state_d = StDone;
                  done_d  = 1'b1;
`endif
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Sequencer state and status registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         op_q      <= OpRead;
         row_q     <= '0;
         col_q     <= '0;
         pw_q      <= 8'd1;
         su_q      <= 4'd1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         result_q  <= 1'b0;
         fail_q    <= 1'b0;
         retries_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         row_q     <= row_d;
         col_q     <= col_d;
         pw_q      <= pw_d;
         su_q      <= su_d;
         done_q    <= done_d;
         err_q     <= err_d;
         result_q  <= result_d;
         fail_q    <= fail_d;
         retries_q <= retries_d;
      end
   end

   // Array drives decode straight from state so an async reset drops them at once.
   always_comb begin
      wl_en    = arr_active ? (RowOne << row_q) : '0;
      bl_en    = arr_active ? (ColOne << col_q) : '0;
      op_set   = arr_active && (op_q == OpSet);
      op_reset = arr_active && (op_q == OpReset);
      pulse    = (state_q == StPulse);
      sense_en = (state_q == StSample);
      irq      = (state_q == StDone);
   end

endmodule

// File: tb/tb_rram_pulse_sequencer.sv
// Directed testbench for rram_pulse_sequencer.
module tb_rram_pulse_sequencer;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni;
   logic        stb, cyc, we;
   logic [31:0] adr, dat_w;
   logic        ack;
   logic [31:0] dat_r;
   logic [15:0] wl_en, bl_en;
   logic        op_set, op_reset, pulse, sense_en, sense_in, irq;

   int n_cmp = 0;
   int n_err = 0;

   // Monitor results
   int          pre_cnt, pulse_cnt, sense_cnt, irq_cnt, oneh_err, opset_cnt, opreset_cnt;
   logic [15:0] wl_at_pulse, bl_at_pulse;

   always #5 wb_clk_i = ~wb_clk_i;

   rram_pulse_sequencer #(
      .ROW_W     (4),
      .COL_W     (4),
      .MAX_RETRY (7)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_w),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_r),
      .wl_en     (wl_en),
      .bl_en     (bl_en),
      .op_set    (op_set),
      .op_reset  (op_reset),
      .pulse     (pulse),
      .sense_en  (sense_en),
      .sense_in  (sense_in),
      .irq       (irq)
   );

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] q);
      int k;
      k     = 0;
      stb   = 1'b1;
      cyc   = 1'b1;
      we    = w;
      adr   = a;
      dat_w = d;
      @(posedge wb_clk_i); #1;
      while (ack !== 1'b1 && k < 4) begin
         @(posedge wb_clk_i); #1;
         k++;
      end
      q   = dat_r;
      stb = 1'b0;
      cyc = 1'b0;
      we  = 1'b0;
      if (ack !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL wb_ack_timeout adr=%h got ack=%b want 1", a, ack);
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] q;
      wb_xfer(1'b1, a, d, q);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
      wb_xfer(1'b0, a, 32'd0, q);
   endtask

   // Watch one operation cycle by cycle until irq (or the budget runs out).
   task automatic monitor(input int limit);
      bit seen;
      seen = 0;
      pre_cnt = 0; pulse_cnt = 0; sense_cnt = 0; irq_cnt = 0; oneh_err = 0;
      opset_cnt = 0; opreset_cnt = 0; wl_at_pulse = '0; bl_at_pulse = '0;
      for (int i = 0; i < limit; i++) begin
         if (pulse) begin
            pulse_cnt++;
            seen        = 1;
            wl_at_pulse = wl_en;
            bl_at_pulse = bl_en;
         end else if (!seen && wl_en != 16'd0) begin
            pre_cnt++;
         end
         if (sense_en) sense_cnt++;
         if (op_set) opset_cnt++;
         if (op_reset) opreset_cnt++;
         if ($countones(wl_en) > 1 || $countones(bl_en) > 1 || (op_set && op_reset))
            oneh_err++;
         if (irq) begin
            irq_cnt++;
            break;
         end
         @(posedge wb_clk_i); #1;
      end
      @(posedge wb_clk_i); #1;
   endtask

   task automatic test_reset;
      logic [31:0] q;
      #1;
      n_cmp++;
      if ({wl_en, bl_en, pulse, op_set, op_reset, sense_en, irq, ack} !== 39'd0) begin
         n_err++;
         $display("FAIL reset_outputs got wl=%h bl=%h p=%b irq=%b want all 0",
                  wl_en, bl_en, pulse, irq);
      end
      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_ni = 1'b1;
      @(posedge wb_clk_i); #1;
      // Single-cycle ack timing on a TIMING read
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4;
      @(posedge wb_clk_i); #1;
      n_cmp++;
      if (ack !== 1'b1) begin
         n_err++;
         $display("FAIL ack_rise got %b want 1", ack);
      end
      n_cmp++;
      if (dat_r !== 32'h20A) begin
         n_err++;
         $display("FAIL reset_timing got %h want 0000020a", dat_r);
      end
      stb = 1'b0; cyc = 1'b0;
      @(posedge wb_clk_i); #1;
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++;
         $display("FAIL ack_fall got %b want 0", ack);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h0) begin
         n_err++;
         $display("FAIL reset_status got %h want 0", q);
      end
      wb_read(32'hC, q);
      n_cmp++;
      if (q !== 32'h0) begin
         n_err++;
         $display("FAIL reg3_read got %h want 0", q);
      end
   endtask

   task automatic test_set_op;
      logic [31:0] q;
      sense_in = 1'b1;
      wb_write(32'h4, 32'h305);
      wb_write(32'h0, 32'h53);
      monitor(100);
      n_cmp++;
      if (pre_cnt !== 3) begin
         n_err++;
         $display("FAIL set_setup_cycles got %0d want 3", pre_cnt);
      end
      n_cmp++;
      if (pulse_cnt !== 5) begin
         n_err++;
         $display("FAIL set_pulse_cycles got %0d want 5", pulse_cnt);
      end
      n_cmp++;
      if (wl_at_pulse !== 16'h0020 || bl_at_pulse !== 16'h0001) begin
         n_err++;
         $display("FAIL set_selects got wl=%h bl=%h want 0020/0001", wl_at_pulse, bl_at_pulse);
      end
      n_cmp++;
`ifdef RRAM_VERIFY_EN
      if (opset_cnt !== 11 || opreset_cnt !== 0) begin
         n_err++;
         $display("FAIL set_bias got set=%0d reset=%0d want 11/0", opset_cnt, opreset_cnt);
      end
`else
      if (opset_cnt !== 9 || opreset_cnt !== 0) begin
         n_err++;
         $display("FAIL set_bias got set=%0d reset=%0d want 9/0", opset_cnt, opreset_cnt);
      end
`endif
      n_cmp++;
      if (irq_cnt !== 1 || oneh_err !== 0) begin
         n_err++;
         $display("FAIL set_irq_onehot got irq=%0d viol=%0d want 1/0", irq_cnt, oneh_err);
      end
      wb_read(32'h8, q);
      n_cmp++;
`ifdef RRAM_VERIFY_EN
      if (q !== 32'h6) begin
         n_err++;
         $display("FAIL set_status got %h want 6", q);
      end
`else
      if (q !== 32'h2) begin
         n_err++;
         $display("FAIL set_status got %h want 2", q);
      end
`endif
   endtask

   task automatic test_read_op;
      logic [31:0] q;
      sense_in = 1'b1;
      wb_write(32'h0, 32'hFF1);
      monitor(100);
      n_cmp++;
      if (sense_cnt !== 2) begin
         n_err++;
         $display("FAIL read_sense_cycles got %0d want 2", sense_cnt);
      end
      n_cmp++;
      if (wl_at_pulse !== 16'h8000 || bl_at_pulse !== 16'h8000) begin
         n_err++;
         $display("FAIL read_selects got wl=%h bl=%h want 8000/8000", wl_at_pulse, bl_at_pulse);
      end
      n_cmp++;
      if (irq_cnt !== 1 || (opset_cnt + opreset_cnt) !== 0) begin
         n_err++;
         $display("FAIL read_irq_bias got irq=%0d bias=%0d want 1/0", irq_cnt,
                  opset_cnt + opreset_cnt);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h6) begin
         n_err++;
         $display("FAIL read_status got %h want 6", q);
      end
   endtask

   task automatic test_busy_err;
      logic [31:0] q;
      sense_in = 1'b1;
      wb_write(32'h4, 32'h040);
      wb_write(32'h0, 32'hFF1);
      wb_write(32'h0, 32'h53);
      n_cmp++;
      if (op_set !== 1'b0) begin
         n_err++;
         $display("FAIL busy_start_op got op_set=%b want 0", op_set);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'hD) begin
         n_err++;
         $display("FAIL busy_status got %h want d", q);
      end
      monitor(200);
      n_cmp++;
      if (irq_cnt !== 1 || opset_cnt !== 0) begin
         n_err++;
         $display("FAIL busy_complete got irq=%0d set=%0d want 1/0", irq_cnt, opset_cnt);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'hE) begin
         n_err++;
         $display("FAIL err_sticky got %h want e", q);
      end
      wb_write(32'h4, 32'h305);
      wb_write(32'h0, 32'hFF1);
      monitor(100);
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h6) begin
         n_err++;
         $display("FAIL err_clear got %h want 6", q);
      end
      // Reserved op must be refused and flagged
      wb_write(32'h0, 32'h007);
      repeat (2) @(posedge wb_clk_i);
      #1;
      n_cmp++;
      if (pulse !== 1'b0 || wl_en !== 16'd0) begin
         n_err++;
         $display("FAIL op3_idle got pulse=%b wl=%h want 0/0000", pulse, wl_en);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'hE) begin
         n_err++;
         $display("FAIL op3_status got %h want e", q);
      end
      wb_write(32'h0, 32'hFF1);
      monitor(100);
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h6) begin
         n_err++;
         $display("FAIL op3_err_clear got %h want 6", q);
      end
   endtask

`ifdef RRAM_VERIFY_EN
   task automatic test_verify;
      logic [31:0] q;
      sense_in = 1'b1;
      wb_write(32'h0, 32'h735);
      monitor(400);
      n_cmp++;
      if (pulse_cnt !== 8 || irq_cnt !== 1) begin
         n_err++;
         $display("FAIL verify_retry_pulses got %0d irq=%0d want 8/1", pulse_cnt, irq_cnt);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h716) begin
         n_err++;
         $display("FAIL verify_fail_status got %h want 716", q);
      end
      sense_in = 1'b0;
      wb_write(32'h0, 32'h735);
      monitor(100);
      n_cmp++;
      if (pulse_cnt !== 1 || irq_cnt !== 1) begin
         n_err++;
         $display("FAIL verify_pass_pulses got %0d irq=%0d want 1/1", pulse_cnt, irq_cnt);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h2) begin
         n_err++;
         $display("FAIL verify_pass_status got %h want 2", q);
      end
   endtask
`else
   task automatic test_reset_op;
      logic [31:0] q;
      sense_in = 1'b0;
      wb_write(32'h0, 32'h735);
      monitor(100);
      n_cmp++;
      if (pulse_cnt !== 5 || sense_cnt !== 0) begin
         n_err++;
         $display("FAIL rst_op_phases got pulse=%0d sense=%0d want 5/0", pulse_cnt, sense_cnt);
      end
      n_cmp++;
      if (opreset_cnt !== 9 || opset_cnt !== 0) begin
         n_err++;
         $display("FAIL rst_op_bias got reset=%0d set=%0d want 9/0", opreset_cnt, opset_cnt);
      end
      n_cmp++;
      if (wl_at_pulse !== 16'h0008 || bl_at_pulse !== 16'h0080) begin
         n_err++;
         $display("FAIL rst_op_selects got wl=%h bl=%h want 0008/0080", wl_at_pulse, bl_at_pulse);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h6) begin
         n_err++;
         $display("FAIL rst_op_status got %h want 6", q);
      end
   endtask
`endif

   task automatic test_timing_latch;
      logic [31:0] q;
      wb_write(32'h4, 32'h305);
      wb_write(32'h0, 32'hFF1);
      wb_write(32'h4, 32'h000);
      monitor(100);
      n_cmp++;
      if (pulse_cnt !== 5) begin
         n_err++;
         $display("FAIL latch_inflight_pw got %0d want 5", pulse_cnt);
      end
      wb_write(32'h0, 32'hFF1);
      monitor(100);
      n_cmp++;
      if (pulse_cnt !== 1 || pre_cnt !== 1) begin
         n_err++;
         $display("FAIL latch_zero_timing got pulse=%0d setup=%0d want 1/1", pulse_cnt, pre_cnt);
      end
      wb_read(32'h4, q);
      n_cmp++;
      if (q !== 32'h0) begin
         n_err++;
         $display("FAIL latch_timing_read got %h want 0", q);
      end
   endtask

   task automatic test_reset_mid_pulse;
      logic [31:0] q;
      int k;
      int bad;
      wb_write(32'h4, 32'h305);
      wb_write(32'h0, 32'h53);
      k = 0;
      while (pulse !== 1'b1 && k < 20) begin
         @(posedge wb_clk_i); #1;
         k++;
      end
      repeat (2) begin
         @(posedge wb_clk_i); #1;
      end
      n_cmp++;
      if (pulse !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_in_pulse got %b want 1", pulse);
      end
      #2 wb_rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (pulse !== 1'b0 || wl_en !== 16'd0 || bl_en !== 16'd0 || op_set !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_async_drop got p=%b wl=%h bl=%h set=%b want 0", pulse, wl_en,
                  bl_en, op_set);
      end
      bad = 0;
      repeat (2) begin
         @(posedge wb_clk_i); #1;
         if (irq || pulse) bad++;
      end
      wb_rst_ni = 1'b1;
      repeat (20) begin
         @(posedge wb_clk_i); #1;
         if (irq || pulse || wl_en != 16'd0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL midrst_no_completion got %0d active cycles want 0", bad);
      end
      wb_read(32'h8, q);
      n_cmp++;
      if (q !== 32'h0) begin
         n_err++;
         $display("FAIL midrst_status got %h want 0", q);
      end
      wb_read(32'h4, q);
      n_cmp++;
      if (q !== 32'h20A) begin
         n_err++;
         $display("FAIL midrst_timing got %h want 20a", q);
      end
   endtask

   initial begin
      wb_rst_ni = 1'b0;
      stb       = 1'b0;
      cyc       = 1'b0;
      we        = 1'b0;
      adr       = 32'd0;
      dat_w     = 32'd0;
      sense_in  = 1'b0;
      test_reset;
      test_set_op;
      test_read_op;
      test_busy_err;
`ifdef RRAM_VERIFY_EN
      test_verify;
`else
      test_reset_op;
`endif
      test_timing_latch;
      test_reset_mid_pulse;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
